wb_stream_reader: RTL and testbench
===================================

WB_STREAM_READER -- requirements
Module: wb_stream_reader

Interface
REQ-001 SHALL have parameter WB_AW, default 32, Wishbone address width.
REQ-002 SHALL have parameter WB_DW, default 32, Wishbone/stream data width.
REQ-003 SHALL have parameter FIFO_AW, default 5, FIFO depth = 2^FIFO_AW words.
REQ-004 SHALL have parameter MAX_BURST_LEN, default 128, upper bound on burst size register in words.
REQ-005 SHALL have port clk  in  1  sole clock, all logic on rising edge.
REQ-006 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have ports wbm_adr_o/wbm_dat_o  out  WB_AW/WB_DW  data master address/write data.
REQ-008 SHALL have ports wbm_sel_o  out  WB_DW/8, wbm_we_o/wbm_cyc_o/wbm_stb_o  out  1  data master controls.
REQ-009 SHALL have ports wbm_cti_o  out  3, wbm_bte_o  out  2  burst type.
REQ-010 SHALL have ports wbm_dat_i  in  WB_DW (unused), wbm_ack_i/wbm_err_i/wbm_rty_i  in  1  data master responses.
REQ-011 SHALL have ports stream_s_data_i  in  WB_DW, stream_s_valid_i  in  1, stream_s_ready_o  out  1  stream sink.
REQ-012 SHALL have ports wbs_adr_i  in  WB_AW, wbs_dat_i  in  WB_DW, wbs_sel_i  in  WB_DW/8, wbs_we_i/wbs_cyc_i/wbs_stb_i  in  1  config slave.
REQ-013 SHALL have ports wbs_cti_i  in  3, wbs_bte_i  in  2, both ignored.
REQ-014 SHALL have ports wbs_dat_o  out  WB_DW, wbs_ack_o/wbs_err_o/wbs_rty_o  out  1  config responses.
REQ-015 SHALL have port irq_o  out  1  completion interrupt.

Function
REQ-016 FIFO: stream_s_ready_o = !full; word pushed when valid&&ready; words arriving while idle retained, never dropped.
REQ-017 Config regs (wbs_adr_i[3:2]): 0x0 ctrl/status, 0x4 start byte address, 0x8 buffer size bytes, 0xC burst size words (clamped to 1..MAX_BURST_LEN on write).
REQ-018 0x0 write bit0=1 starts transfer only when idle and size>=4; read bit0=busy, bit1=irq pending, bit2=bus error.
REQ-019 Writes to 0x4/0x8/0xC while busy SHALL be ignored; all regs read back value held.
REQ-020 wbs_ack_o pulses one cycle after cyc&stb&!ack; wbs_err_o=wbs_rty_o=0; no back-to-back acks.
REQ-021 FSM IDLE->WAIT on start; WAIT->BURST when FIFO count >= L, L=min(burst size, remaining words).
REQ-022 BURST: cyc=stb=we=1, sel=all ones, bte=00, cti=010, cti=111 on final beat; L=1 uses cti=111.
REQ-023 On each ack: pop FIFO, adr += WB_DW/8, remaining -= 1; wbm_dat_o = FIFO head, no bubbles.
REQ-024 After last beat: cyc/stb low next cycle; remaining>0 -> WAIT, else IDLE with busy=0.
REQ-025 wbm_rty_i treated as no ack; wbm_err_i drops cyc/stb, sets error bit, -> IDLE, no irq.
REQ-026 Buffer size SHALL be truncated to whole words (low 2 bits ignored); remaining counter width WB_AW.

Reset
REQ-027 rst SHALL clear FIFO, FSM to IDLE, all regs to 0 (burst size to 1), all outputs 0 except stream_s_ready_o=1; effective mid-burst at the next edge.
REQ-028 After reset deassertion block SHALL accept config accesses on the first following cycle.

Configuration
REQ-029 Macro WB_STREAM_READER_IRQ_EN defined: completion sets irq pending, irq_o=pending, cleared by writing 0x0 bit1=1.
REQ-030 Macro undefined: irq_o tied 0, status bit1 reads 0, clear writes no effect.

Verification
REQ-031 start=0x40, size=32, burst=8, stream 8 words 0x1..0x8 -> one burst adr 0x40..0x5C, cti 010x7 then 111, RAM matches.
REQ-032 size=40, burst=8 -> bursts of 8 and 2 words, second starting at adr start+0x20, busy clears after.
REQ-033 stream 40 words with FIFO_AW=5 while idle -> ready low after 32 accepted, no loss once transfer started.
REQ-034 wbm_err_i asserted on beat 3 -> cyc low next cycle, status=0x4, irq_o stays 0.
REQ-035 with IRQ_EN, complete 16-byte transfer -> irq_o=1, status 0x2; write 0x0=0x2 -> irq_o=0 next cycle.
REQ-036 rst asserted mid-burst -> cyc/stb 0 next cycle, FIFO empty, status reads 0.

Source files
------------

// File: rtl/wb_stream_reader.sv
// wb_stream_reader: buffers a valid/ready stream in a FIFO and writes it to memory as Wishbone bursts.
// Ports: clk/rst (sync, active-high); wbm_* Wishbone data master (write-only bursts);
// stream_s_* stream sink; wbs_* config slave (0x0 ctrl/status, 0x4 start address,
// 0x8 buffer size in bytes, 0xC burst size in words); irq_o completion interrupt.
// Optional macro WB_STREAM_READER_IRQ_EN enables the completion interrupt.
module wb_stream_reader #(
  parameter int WB_AW = 32,
  parameter int WB_DW = 32,
  parameter int FIFO_AW = 5,
  parameter int MAX_BURST_LEN = 128
) (
  input  logic               clk,
  input  logic               rst,
  output logic [WB_AW-1:0]   wbm_adr_o,
  output logic [WB_DW-1:0]   wbm_dat_o,
  output logic [WB_DW/8-1:0] wbm_sel_o,
  output logic               wbm_we_o,
  output logic               wbm_cyc_o,
  output logic               wbm_stb_o,
  output logic [2:0]         wbm_cti_o,
  output logic [1:0]         wbm_bte_o,
  input  logic [WB_DW-1:0]   wbm_dat_i,
  input  logic               wbm_ack_i,
  input  logic               wbm_err_i,
  input  logic               wbm_rty_i,
  input  logic [WB_DW-1:0]   stream_s_data_i,
  input  logic               stream_s_valid_i,
  output logic               stream_s_ready_o,
  input  logic [WB_AW-1:0]   wbs_adr_i,
  input  logic [WB_DW-1:0]   wbs_dat_i,
  input  logic [WB_DW/8-1:0] wbs_sel_i,
  input  logic               wbs_we_i,
  input  logic               wbs_cyc_i,
  input  logic               wbs_stb_i,
  input  logic [2:0]         wbs_cti_i,
  input  logic [1:0]         wbs_bte_i,
  output logic [WB_DW-1:0]   wbs_dat_o,
  output logic               wbs_ack_o,
  output logic               wbs_err_o,
  output logic               wbs_rty_o,
  output logic               irq_o
);
  localparam int BW = WB_DW / 8;
  localparam int SH = $clog2(BW);
  localparam int DEPTH = 1 << FIFO_AW;
  typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;
  state_t state;
  logic [WB_DW-1:0] mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0] count;
  logic full, push, pop;
  logic [WB_DW-1:0] start_adr, size, burst, rdata;
  logic [WB_AW-1:0] addr, remaining, beats, words, blen, len;
  logic irq_pend, err_flag, req, wr, start;
  logic [1:0] reg_sel;
  logic unused;
  assign unused = ^{wbm_dat_i, wbm_rty_i, wbs_sel_i, wbs_cti_i, wbs_bte_i, wbs_adr_i[WB_AW-1:4], wbs_adr_i[1:0]};
  assign full = count[FIFO_AW];
  assign stream_s_ready_o = !full;
  assign push = stream_s_valid_i && !full;
  assign pop = state == BURST && wbm_ack_i && !wbm_err_i;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= stream_s_data_i;
  always_ff @(posedge clk)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + FIFO_AW'(push);
      rd_ptr <= rd_ptr + FIFO_AW'(pop);
      count <= count + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
    end
  assign req = wbs_cyc_i && wbs_stb_i && !wbs_ack_o;
  assign wr = req && wbs_we_i;
  assign reg_sel = wbs_adr_i[3:2];
  assign start = wr && reg_sel == 2'd0 && wbs_dat_i[0] && size >= WB_DW'(BW);
  assign rdata = reg_sel == 2'd0 ? WB_DW'({err_flag, irq_pend, state != IDLE}) :
                 reg_sel == 2'd1 ? start_adr : reg_sel == 2'd2 ? size : burst;
  assign words = WB_AW'(size >> SH);
  // A burst never asks for more words than the FIFO can hold, otherwise WAIT could never be satisfied.
  assign blen = WB_AW'(burst) < WB_AW'(DEPTH) ? WB_AW'(burst) : WB_AW'(DEPTH);
  assign len = blen < remaining ? blen : remaining;
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      start_adr <= '0;
      size <= '0;
      burst <= WB_DW'(1);
      irq_pend <= 1'b0;
      err_flag <= 1'b0;
      addr <= '0;
      remaining <= '0;
      beats <= '0;
      wbm_cyc_o <= 1'b0;
      wbm_cti_o <= 3'b000;
    end else begin
      wbs_ack_o <= req;
      wbs_dat_o <= req ? rdata : '0;
      if (wr && state == IDLE && reg_sel == 2'd1) start_adr <= wbs_dat_i;
      if (wr && state == IDLE && reg_sel == 2'd2) size <= wbs_dat_i & ~WB_DW'(BW - 1);
      if (wr && state == IDLE && reg_sel == 2'd3)
        burst <= wbs_dat_i == '0 ? WB_DW'(1) :
                 wbs_dat_i > WB_DW'(MAX_BURST_LEN) ? WB_DW'(MAX_BURST_LEN) : wbs_dat_i;
`ifdef WB_STREAM_READER_IRQ_EN
      if (wr && reg_sel == 2'd0 && wbs_dat_i[1]) irq_pend <= 1'b0;
`endif
      case (state)
        IDLE: if (start) begin
          state <= WAIT;
          addr <= WB_AW'(start_adr);
          remaining <= words;
          err_flag <= 1'b0;
        end
        WAIT: if (WB_AW'(count) >= len) begin
          state <= BURST;
          beats <= len;
          wbm_cyc_o <= 1'b1;
          wbm_cti_o <= len == 1 ? 3'b111 : 3'b010;
        end
        BURST: if (wbm_err_i) begin
          state <= IDLE;
          wbm_cyc_o <= 1'b0;
          wbm_cti_o <= 3'b000;
          err_flag <= 1'b1;
        end else if (wbm_ack_i) begin
          addr <= addr + WB_AW'(BW);
          remaining <= remaining - 1'b1;
          beats <= beats - 1'b1;
          wbm_cti_o <= beats == 1 ? 3'b000 : beats == 2 ? 3'b111 : wbm_cti_o;
          if (beats == 1) begin
            wbm_cyc_o <= 1'b0;
            state <= remaining == 1 ? IDLE : WAIT;
`ifdef WB_STREAM_READER_IRQ_EN
            if (remaining == 1) irq_pend <= 1'b1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  assign wbm_adr_o = addr;
  assign wbm_dat_o = wbm_cyc_o ? mem[rd_ptr] : '0;
  assign wbm_sel_o = {BW{wbm_cyc_o}};
  assign wbm_we_o = wbm_cyc_o;
  assign wbm_stb_o = wbm_cyc_o;
  assign wbm_bte_o = 2'b00;
  assign wbs_err_o = 1'b0;
  assign wbs_rty_o = 1'b0;
`ifdef WB_STREAM_READER_IRQ_EN
  assign irq_o = irq_pend;
`else
  assign irq_o = 1'b0;
`endif
endmodule

// File: tb/tb_wb_stream_reader.sv
// tb_wb_stream_reader: randomized self-checking bench for wb_stream_reader against a transfer-level model.
module tb_wb_stream_reader;
  localparam int MAXB = 128;
  localparam int DEPTH = 32;
`ifdef WB_STREAM_READER_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i, stream_s_data_i, wbs_adr_i, wbs_dat_i, wbs_dat_o;
  logic [3:0] wbm_sel_o, wbs_sel_i;
  logic wbm_we_o, wbm_cyc_o, wbm_stb_o, wbm_ack_i, wbm_err_i, wbm_rty_i;
  logic [2:0] wbm_cti_o, wbs_cti_i;
  logic [1:0] wbm_bte_o, wbs_bte_i;
  logic stream_s_valid_i, stream_s_ready_o;
  logic wbs_we_i, wbs_cyc_i, wbs_stb_i, wbs_ack_o, wbs_err_o, wbs_rty_o, irq_o;
  wb_stream_reader #(.WB_AW(32), .WB_DW(32), .FIFO_AW(5), .MAX_BURST_LEN(MAXB)) dut (
    .clk(clk), .rst(rst),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o), .wbm_we_o(wbm_we_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i), .wbm_rty_i(wbm_rty_i),
    .stream_s_data_i(stream_s_data_i), .stream_s_valid_i(stream_s_valid_i), .stream_s_ready_o(stream_s_ready_o),
    .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_sel_i(wbs_sel_i), .wbs_we_i(wbs_we_i),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_cti_i(wbs_cti_i), .wbs_bte_i(wbs_bte_i),
    .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o), .wbs_rty_o(wbs_rty_o),
    .irq_o(irq_o)
  );
  always #5 clk = ~clk;
  int vectors = 0;
  int errors = 0;
  int err_at = -1;
  int beat_no = 0;
  int accepted = 0;
  bit feed_en = 1'b1;
  logic [31:0] src[$], exp_adr[$], exp_dat[$], obs_adr[$], obs_dat[$];
  logic [2:0] exp_cti[$], obs_cti[$];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic wb_access(input logic we, input logic [3:0] a, input logic [31:0] d, output logic [31:0] q);
    int t = 0;
    @(negedge clk);
    wbs_adr_i = {28'h0, a};
    wbs_dat_i = d;
    wbs_we_i = we;
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    do begin
      @(negedge clk);
      t++;
    end while (!wbs_ack_o && t < 8);
    check("wbs_ack", {31'h0, wbs_ack_o}, 32'h1);
    q = wbs_dat_o;
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i = 1'b0;
  endtask
  task automatic wb_write(input logic [3:0] a, input logic [31:0] d);
    logic [31:0] q;
    wb_access(1'b1, a, d, q);
  endtask
  task automatic wb_read(input logic [3:0] a, output logic [31:0] q);
    wb_access(1'b0, a, 32'h0, q);
  endtask
  // Stream source: offers queued words with random gaps; a word counts as taken when ready is seen.
  initial begin
    stream_s_valid_i = 1'b0;
    stream_s_data_i = '0;
    forever begin
      @(negedge clk);
      if (feed_en && src.size() > 0 && $urandom_range(0, 3) != 0) begin
        stream_s_valid_i = 1'b1;
        stream_s_data_i = src[0];
        if (stream_s_ready_o && !rst) begin
          void'(src.pop_front());
          accepted++;
        end
      end else stream_s_valid_i = 1'b0;
    end
  end
  // Memory-side slave: random ack / retry / wait states, optional error on a chosen beat.
  initial begin
    wbm_ack_i = 1'b0;
    wbm_err_i = 1'b0;
    wbm_rty_i = 1'b0;
    wbm_dat_i = '0;
    forever begin
      @(negedge clk);
      wbm_ack_i = 1'b0;
      wbm_err_i = 1'b0;
      wbm_rty_i = 1'b0;
      if (wbm_cyc_o && wbm_stb_o && !rst) begin
        if (beat_no == err_at) wbm_err_i = 1'b1;
        else case ($urandom_range(0, 3))
          0: wbm_rty_i = 1'b1;
          1: ;
          default: begin
            wbm_ack_i = 1'b1;
            check("wbm_sel", {28'h0, wbm_sel_o}, 32'hf);
            check("wbm_we_bte", {29'h0, wbm_we_o, wbm_bte_o}, 32'h4);
            obs_adr.push_back(wbm_adr_o);
            obs_dat.push_back(wbm_dat_o);
            obs_cti.push_back(wbm_cti_o);
            beat_no++;
          end
        endcase
      end
    end
  end
  task automatic setup(input logic [31:0] start, input logic [31:0] size, input logic [31:0] burst);
    logic [31:0] q, d;
    int n, rem, l, b;
    wb_write(4'h4, start);
    wb_write(4'h8, size);
    wb_write(4'hC, burst);
    wb_read(4'h4, q);
    check("start_rd", q, start);
    wb_read(4'h8, q);
    check("size_rd", q, size & ~32'h3);
    b = burst == 0 ? 1 : burst > MAXB ? MAXB : int'(burst);
    wb_read(4'hC, q);
    check("burst_rd", q, b);
    exp_adr.delete(); exp_dat.delete(); exp_cti.delete();
    obs_adr.delete(); obs_dat.delete(); obs_cti.delete();
    beat_no = 0;
    n = int'(size >> 2);
    for (int i = 0; i < n; i++) begin
      d = $urandom();
      exp_adr.push_back(start + 32'(4 * i));
      exp_dat.push_back(d);
      src.push_back(d);
    end
    rem = n;
    while (rem > 0) begin
      l = b < rem ? b : rem;
      for (int j = 0; j < l; j++) exp_cti.push_back(j == l - 1 ? 3'b111 : 3'b010);
      rem -= l;
    end
  endtask
  task automatic go_and_check(input logic [31:0] size);
    logic [31:0] q;
    int t = 0;
    wb_write(4'h0, 32'h1);
    if ((size >> 2) >= 4) begin
      wb_write(4'h8, 32'h0);
      wb_read(4'h8, q);
      check("size_busy_wr", q, size & ~32'h3);
    end
    do begin
      wb_read(4'h0, q);
      t++;
    end while (q[0] && t < 3000);
    check("status_done", q, IRQ ? 32'h2 : 32'h0);
    check("irq_set", {31'h0, irq_o}, {31'h0, IRQ});
    check("beats", obs_adr.size(), exp_adr.size());
    while (obs_adr.size() > 0 && exp_adr.size() > 0) begin
      check("adr", obs_adr.pop_front(), exp_adr.pop_front());
      check("dat", obs_dat.pop_front(), exp_dat.pop_front());
      check("cti", {29'h0, obs_cti.pop_front()}, {29'h0, exp_cti.pop_front()});
    end
    wb_write(4'h0, 32'h2);
    check("irq_clr", {31'h0, irq_o}, 32'h0);
    check("ready_idle", {31'h0, stream_s_ready_o}, 32'h1);
  endtask
  initial begin
    logic [31:0] q;
    int t, n;
    wbs_adr_i = '0; wbs_dat_i = '0; wbs_sel_i = 4'hf; wbs_we_i = 1'b0;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_cti_i = '0; wbs_bte_i = '0;
    repeat (3) @(negedge clk);
    check("rst_outs", {26'h0, wbm_cyc_o, wbm_stb_o, stream_s_ready_o, irq_o, wbs_ack_o, wbm_we_o}, 32'h8);
    rst = 1'b0;
    wb_read(4'h0, q); check("rst_status", q, 32'h0);
    wb_read(4'hC, q); check("rst_burst", q, 32'h1);
    wb_read(4'h8, q); check("rst_size", q, 32'h0);
    wb_write(4'hC, 32'h0); wb_read(4'hC, q); check("burst_min", q, 32'h1);
    wb_write(4'hC, 32'd1000); wb_read(4'hC, q); check("burst_max", q, MAXB);
    wb_write(4'h8, 32'h23); wb_read(4'h8, q); check("size_trunc", q, 32'h20);
    wb_write(4'h8, 32'h3); wb_write(4'h0, 32'h1);
    wb_read(4'h0, q); check("no_start_small", q, 32'h0);
    setup(32'h40, 32, 8); go_and_check(32);
    setup(32'h100, 40, 8); go_and_check(40);
    setup(32'h200, 12, 1); go_and_check(12);
    repeat (12) begin
      n = $urandom_range(1, 48);
      setup($urandom() & 32'hFFFF_FFFC, 32'(n * 4 + $urandom_range(0, 3)), $urandom_range(1, 32));
      repeat ($urandom_range(0, 20)) @(negedge clk);
      go_and_check(32'(n * 4));
    end
    accepted = 0;
    setup(32'h2000, 160, 16);
    repeat (120) @(negedge clk);
    check("ovf_ready", {31'h0, stream_s_ready_o}, 32'h0);
    check("ovf_count", accepted, DEPTH);
    go_and_check(160);
    setup(32'h3000, 32, 8);
    err_at = 2;
    wb_write(4'h0, 32'h1);
    t = 0;
    do begin
      @(posedge clk);
      t++;
    end while (!wbm_err_i && t < 500);
    check("err_seen", {31'h0, wbm_err_i}, 32'h1);
    @(negedge clk);
    check("err_cyc", {30'h0, wbm_cyc_o, wbm_stb_o}, 32'h0);
    err_at = -1;
    wb_read(4'h0, q); check("err_status", q, 32'h4);
    check("err_irq", {31'h0, irq_o}, 32'h0);
    setup(32'h4000, 128, 16);
    wb_write(4'h0, 32'h1);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (beat_no < 3 && t < 1000);
    check("mid_burst", {31'h0, wbm_cyc_o}, 32'h1);
    rst = 1'b1;
    feed_en = 1'b0;
    @(negedge clk);
    check("rst_mid_cyc", {30'h0, wbm_cyc_o, wbm_stb_o}, 32'h0);
    check("rst_mid_ready", {31'h0, stream_s_ready_o}, 32'h1);
    rst = 1'b0;
    src.delete();
    feed_en = 1'b1;
    wb_read(4'h0, q); check("rst_mid_status", q, 32'h0);
    setup(32'h5000, 20, 4); go_and_check(20);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
